// File: rtl/axis_deserializer_keep_pkg.sv
// rtl/axis_deserializer_keep_pkg.sv - shared encodings and sizing helper for the keep-aware deserializer
package axis_deserializer_keep_pkg;

  localparam int AXIS_ORDER_LSB_FIRST = 0;
  localparam int AXIS_ORDER_MSB_FIRST = 1;

  // Slot counter width; a single-word beat still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_deserializer_keep.sv
// rtl/axis_deserializer_keep.sv - packs DATA_NB narrow words into one wide stream beat with keep mask
module axis_deserializer_keep
  import axis_deserializer_keep_pkg::*;
#(
  parameter int DATA_NB    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ORDER      = AXIS_ORDER_LSB_FIRST,
  parameter int ZERO_FILL  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic [DATA_WIDTH-1:0]         up_data,
  input  logic                          up_last,
  output logic                          down_valid,
  input  logic                          down_ready,
  output logic [DATA_WIDTH*DATA_NB-1:0] down_data,
  output logic [DATA_NB-1:0]            down_keep,
  output logic                          down_last
);

  localparam int CW = cnt_width(DATA_NB);
  localparam int BW = DATA_WIDTH * DATA_NB;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_NB - 1);

  logic [CW-1:0]      cnt;
  logic [CW-1:0]      slot;
  logic [BW-1:0]      stage_data;
  logic [BW-1:0]      merged_data;
  logic [DATA_NB-1:0] stage_keep;
  logic [DATA_NB-1:0] merged_keep;
  logic               beat_completes;
  logic               accept;

  // Only the completing word has to wait for the output register to free up.
  assign beat_completes = (cnt == LAST_CNT) | up_last;
  assign up_ready       = ~down_valid | down_ready | ~beat_completes;
  assign accept         = up_valid & up_ready;
  assign slot           = (ORDER == AXIS_ORDER_MSB_FIRST) ? (LAST_CNT - cnt) : cnt;

  // Staging contents as they would look with the current word merged in.
  always_comb begin
    merged_data = stage_data;
    merged_keep = stage_keep;
    if ((cnt == '0) && (ZERO_FILL != 0)) begin
      merged_data = '0;
    end
    merged_data[slot*DATA_WIDTH +: DATA_WIDTH] = up_data;
    merged_keep[slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      stage_data <= '0;
      stage_keep <= '0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_keep  <= '0;
      down_last  <= 1'b0;
    end else begin
      if (down_valid && down_ready) begin
        down_valid <= 1'b0;
      end
      if (accept) begin
        stage_data <= merged_data;
        if (beat_completes) begin
          down_valid <= 1'b1;
          down_data  <= merged_data;
          down_keep  <= merged_keep;
          down_last  <= up_last;
          cnt        <= '0;
          stage_keep <= '0;
        end else begin
          cnt        <= cnt + 1'b1;
          stage_keep <= merged_keep;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_deserializer_keep.sv
// tb/tb_axis_deserializer_keep.sv - randomized and directed bench with a word-list reference model
module tb_axis_deserializer_keep;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_valid, up_last, down_ready;
  logic [W-1:0]  up_data;
  logic          ur0, dv0, dl0, ur1, dv1, dl1;
  logic [N*W-1:0] dd0, dd1;
  logic [N-1:0]  dk0, dk1;

  int checks = 0;
  int errors = 0;

  // Reference: list of words in the beat under construction plus the expected output register.
  logic [W-1:0]   m_words[$];
  logic           m_valid, m_last;
  logic [N*W-1:0] m_data0, m_data1;
  logic [N-1:0]   m_keep0, m_keep1;

  always #5 clk = ~clk;

  axis_deserializer_keep #(.DATA_NB(N), .DATA_WIDTH(W), .ORDER(0), .ZERO_FILL(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur0), .up_data(up_data),
    .up_last(up_last), .down_valid(dv0), .down_ready(down_ready), .down_data(dd0),
    .down_keep(dk0), .down_last(dl0));

  axis_deserializer_keep #(.DATA_NB(N), .DATA_WIDTH(W), .ORDER(1), .ZERO_FILL(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur1), .up_data(up_data),
    .up_last(up_last), .down_valid(dv1), .down_ready(down_ready), .down_data(dd1),
    .down_keep(dk1), .down_last(dl1));

  task automatic model_reset();
    m_words.delete();
    m_valid = 1'b0; m_last = 1'b0;
    m_data0 = '0; m_data1 = '0; m_keep0 = '0; m_keep1 = '0;
  endtask

  function automatic logic model_ready(input logic ul, input logic dr);
    return !m_valid || dr || !((m_words.size() == N - 1) || ul);
  endfunction

  task automatic model_edge(input logic uv, input logic [W-1:0] ud, input logic ul, input logic dr);
    logic acc;
    acc = uv && model_ready(ul, dr);
    if (m_valid && dr) m_valid = 1'b0;
    if (acc) begin
      m_words.push_back(ud);
      if (m_words.size() == N || ul) begin
        m_data0 = '0; m_data1 = '0; m_keep0 = '0; m_keep1 = '0;
        for (int i = 0; i < m_words.size(); i++) begin
          m_data0[i*W +: W] = m_words[i];
          m_keep0[i] = 1'b1;
          m_data1[(N-1-i)*W +: W] = m_words[i];
          m_keep1[N-1-i] = 1'b1;
        end
        m_valid = 1'b1;
        m_last  = ul;
        m_words.delete();
      end
    end
  endtask

  // Starts and ends at a falling edge so outputs are sampled away from the active edge.
  task automatic drive_cycle(input logic uv, input logic [W-1:0] ud, input logic ul, input logic dr,
                             output logic [1:0] got_ready, output logic exp_ready);
    up_valid = uv; up_data = ud; up_last = ul; down_ready = dr;
    #1;
    got_ready = {ur1, ur0};
    exp_ready = model_ready(ul, dr);
    @(posedge clk);
    model_edge(uv, ud, ul, dr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; up_valid = 1'b0; up_data = '0; up_last = 1'b0; down_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({dv0, dk0, dl0, dd0, dv1, dk1, dl1, dd1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got dv=%b keep=%h last=%b data=%h / dv=%b keep=%h last=%b data=%h, want all zero",
               dv0, dk0, dl0, dd0, dv1, dk1, dl1, dd1);
    end
    checks++;
    if ({ur1, ur0} !== 2'b11) begin
      errors++; $display("FAIL reset_up_ready got %b want 11", {ur1, ur0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    logic [1:0] gr; logic er;
    for (int i = 0; i < 9; i++) begin
      drive_cycle(i < 8, W'(i + 1), 1'b0, 1'b1, gr, er);
      checks++;
      if (gr !== 2'b11 || er !== 1'b1) begin
        errors++; $display("FAIL cont_up_ready cycle %0d got %b want 11", i, gr);
      end
      checks++;
      if ({dv0, dk0, dl0, dd0, dv1, dk1, dl1, dd1} !== {m_valid, m_keep0, m_last, m_data0, m_valid, m_keep1, m_last, m_data1}) begin
        errors++;
        $display("FAIL cont_beat cycle %0d got %b %h %b %h / %b %h %b %h want %b %h %b %h / %h %h",
                 i, dv0, dk0, dl0, dd0, dv1, dk1, dl1, dd1, m_valid, m_keep0, m_last, m_data0, m_keep1, m_data1);
      end
      if (i == 3) begin
        checks++;
        if (dv0 !== 1'b1 || dd0 !== 32'h04030201 || dk0 !== 4'hF || dl0 !== 1'b0 || dd1 !== 32'h01020304 || dk1 !== 4'hF) begin
          errors++; $display("FAIL cont_first_beat got lsb=%h/%h msb=%h/%h want 04030201/f 01020304/f", dd0, dk0, dd1, dk1);
        end
      end
      if (i == 7) begin
        checks++;
        if (dv0 !== 1'b1 || dd0 !== 32'h08070605 || dd1 !== 32'h05060708) begin
          errors++; $display("FAIL cont_second_beat got %h %h want 08070605 05060708", dd0, dd1);
        end
      end
    end
    checks++;
    if (dv0 !== 1'b0 || dv1 !== 1'b0) begin
      errors++; $display("FAIL cont_drain got %b %b want 0 0", dv0, dv1);
    end
  endtask

  task automatic test_short_packets();
    logic [1:0] gr; logic er;
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b1, gr, er);
    drive_cycle(1'b1, 8'hBB, 1'b1, 1'b1, gr, er);
    checks++;
    if (dv0 !== 1'b1 || dd0 !== 32'h0000BBAA || dk0 !== 4'b0011 || dl0 !== 1'b1 ||
        dd1 !== 32'hAABB0000 || dk1 !== 4'b1100 || dl1 !== 1'b1) begin
      errors++; $display("FAIL short_two_words got %h/%b/%b %h/%b want 0000bbaa/0011/1 aabb0000/1100", dd0, dk0, dl0, dd1, dk1);
    end
    drive_cycle(1'b1, 8'hCC, 1'b1, 1'b1, gr, er);
    checks++;
    if (dd0 !== 32'h000000CC || dk0 !== 4'b0001 || dd1 !== 32'hCC000000 || dk1 !== 4'b1000 || dl1 !== 1'b1) begin
      errors++; $display("FAIL short_single_word got %h/%b %h/%b want 000000cc/0001 cc000000/1000", dd0, dk0, dd1, dk1);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, gr, er);
  endtask

  task automatic test_backpressure();
    logic [1:0] gr; logic er;
    int idx = 0;
    int low_idx = -1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      drive_cycle(idx < 8, W'(8'h10 + idx), 1'b0, cyc >= 15, gr, er);
      if (gr[0] === 1'b0 && low_idx < 0) low_idx = idx;
      checks++;
      if (gr !== {2{er}}) begin
        errors++; $display("FAIL bp_up_ready cycle %0d got %b want %b", cyc, gr, {2{er}});
      end
      if (idx < 8 && gr[0] === 1'b1) idx++;
      checks++;
      if ({dv0, dk0, dl0, dd0, dv1, dk1, dl1, dd1} !== {m_valid, m_keep0, m_last, m_data0, m_valid, m_keep1, m_last, m_data1}) begin
        errors++; $display("FAIL bp_beat cycle %0d got %b %h %h want %b %h %h", cyc, dv0, dd0, dd1, m_valid, m_data0, m_data1);
      end
      if (cyc == 14) begin
        checks++;
        if (dv0 !== 1'b1 || dd0 !== 32'h13121110 || idx != 7) begin
          errors++; $display("FAIL bp_hold got dv=%b data=%h accepted=%0d want 1 13121110 7", dv0, dd0, idx);
        end
      end
      if (cyc == 15) begin
        checks++;
        if (dv0 !== 1'b1 || dd0 !== 32'h17161514 || dk0 !== 4'hF) begin
          errors++; $display("FAIL bp_reload got dv=%b data=%h keep=%h want 1 17161514 f", dv0, dd0, dk0);
        end
      end
    end
    checks++;
    if (low_idx != 7 || idx != 8) begin
      errors++; $display("FAIL bp_stall_point got first stall at word %0d, accepted %0d, want 7 and 8", low_idx, idx);
    end
  endtask

  task automatic test_random();
    logic [1:0] gr; logic er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) != 0, gr, er);
      checks++;
      if (gr !== {2{er}}) begin
        errors++; $display("FAIL rand_up_ready cycle %0d got %b want %b", cyc, gr, {2{er}});
      end
      checks++;
      if ({dv0, dk0, dl0, dd0, dv1, dk1, dl1, dd1} !== {m_valid, m_keep0, m_last, m_data0, m_valid, m_keep1, m_last, m_data1}) begin
        errors++;
        $display("FAIL rand_beat cycle %0d got %b %h %b %h / %h %h want %b %h %b %h / %h %h",
                 cyc, dv0, dk0, dl0, dd0, dk1, dd1, m_valid, m_keep0, m_last, m_data0, m_keep1, m_data1);
      end
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, gr, er);
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    logic [1:0] gr; logic er;
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, W'(8'h40 + i), 1'b0, 1'b0, gr, er);
    checks++;
    if (dv0 !== 1'b1 || dd0 !== 32'h43424140) begin
      errors++; $display("FAIL mid_pre_reset got dv=%b data=%h want 1 43424140", dv0, dd0);
    end
    up_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dv0, dk0, dl0, dd0, dv1, dk1, dl1, dd1} !== '0) begin
      errors++; $display("FAIL mid_async_reset got dv=%b keep=%h data=%h / dv=%b data=%h want zero", dv0, dk0, dd0, dv1, dd1);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, W'(8'h21 + i), 1'b0, 1'b1, gr, er);
      checks++;
      if ({dv0, dk0, dl0, dd0, dv1, dk1, dl1, dd1} !== {m_valid, m_keep0, m_last, m_data0, m_valid, m_keep1, m_last, m_data1}) begin
        errors++; $display("FAIL mid_after_beat cycle %0d got %b %h %h want %b %h %h", i, dv0, dd0, dd1, m_valid, m_data0, m_data1);
      end
    end
    checks++;
    if (dv0 !== 1'b1 || dd0 !== 32'h24232221 || dk0 !== 4'hF || dd1 !== 32'h21222324) begin
      errors++; $display("FAIL mid_clean_beat got %b %h %h %h want 1 24232221 f 21222324", dv0, dd0, dk0, dd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_continuous();
    test_short_packets();
    test_backpressure();
    test_random();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
